plru_tree_set_ctrl: RTL
=======================

// Module: plru_tree_set_ctrl
// PURPOSE
//  Parametrised multi-set tree pseudo-LRU controller for a WAYS-way, SETS-set cache.
//  - Holds one (WAYS-1)-bit PLRU tree per set and updates it from multi-hot access maps.
//  - Answers victim requests through a valid/ready handshake, with invalid-way priority and per-way lock masking.
//  - Sits beside the tag array: hit logic drives access_*, the refill path drives victim_*.
// PARAMETERS
//  WAYS            8   ways per set; power of 2, >=2
//  SETS            64  number of sets; >=1
//  SET_W           $clog2(SETS) (min 1)  set index width; derived, do not override
//  WAY_W           $clog2(WAYS)          way index width; derived, do not override
//  UPDATE_ON_VICT  0   1: an accepted victim request also marks the chosen way as accessed
// PORTS
//  clk_i              in   1      clock
//  rstn_i             in   1      reset, asynchronous, active-low
//  flush_i            in   1      clear all trees to 0 (one-cycle pulse)
//  access_vld_i       in   1      access map valid this cycle
//  access_set_i       in   SET_W  set being accessed
//  access_map_i       in   WAYS   multi-hot map of accessed ways
//  vreq_vld_i         in   1      victim request valid
//  vreq_rdy_o         out  1      victim request ready
//  vreq_set_i         in   SET_W  set to pick a victim from
//  vreq_valid_map_i   in   WAYS   line-valid bits of the set
//  vreq_lock_map_i    in   WAYS   ways that must not be chosen
//  vrsp_vld_o         out  1      victim response valid
//  vrsp_rdy_i         in   1      victim response ready
//  vrsp_way_o         out  WAY_W  chosen way index
//  vrsp_onehot_o      out  WAYS   chosen way, one-hot (0 if all locked)
//  vrsp_all_locked_o  out  1      every way is locked; no victim
// BEHAVIOUR
//  Tree layout and node meaning:
//  - Heap order: node i has children 2i+1 (low ways) and 2i+2 (high ways).
//  - Way w is leaf WAYS-1+w.
//  - Node bit 0 = the old (victim) side is the low half; 1 = the high half.
//  Update (any cycle, per set):
//  - A node flips iff any accessed way lies in the subtree it currently points to; otherwise it holds.
//  - All nodes evaluate in parallel against the current state.
//  - If both halves are touched, the node flips.
//  - An access map of all zeros is a no-op.
//  Victim request:
//  - Accepted when vreq_vld_i & vreq_rdy_o.
//  - vreq_rdy_o = ~flush_i & (~vrsp_vld_o | vrsp_rdy_i).
//  - Victim is computed combinationally at acceptance and registered into the vrsp_* outputs; vrsp_vld_o is high the next cycle (latency 1).
//  - Full throughput when vrsp_rdy_i is held high.
//  Victim selection, in priority order:
//  1. Lowest-index way with valid=0 and lock=0.
//  2. Tree walk from the root following each node bit. At any node whose pointed subtree is fully locked, take the other child.
//  3. All ways locked: vrsp_all_locked_o=1, vrsp_way_o=0, vrsp_onehot_o=0.
//  - The walk uses the tree state before any same-cycle update. A same-cycle access to the same set affects only the next request.
//  - UPDATE_ON_VICT=1: the chosen one-hot is ORed into the access map of the same set in the acceptance cycle. Same-set and different-set simultaneous updates are both applied. No update when all locked.
//  Response hold:
//  - While vrsp_vld_o & ~vrsp_rdy_i, all vrsp_* outputs hold stable.
//  - vrsp_vld_o drops after the handshake unless a new request is accepted in the same cycle.
//  Flush:
//  - flush_i clears every tree bit at the next edge and has priority over same-cycle access updates.
//  - A pending response is kept unchanged.
//  Reset:
//  - All tree bits 0; vrsp_vld_o=0, vrsp_way_o=0, vrsp_onehot_o=0, vrsp_all_locked_o=0.
//  - Reset mid-handshake drops the pending response.
//  Constraints:
//  - access_set_i / vreq_set_i >= SETS is illegal and covered by an assertion.
//  - Updates to other sets never alter a set's tree.
// TESTING (WAYS=8, SETS=4, UPDATE_ON_VICT=0 unless noted)
//  1. After reset, vreq set2, valid=FF, lock=00 -> next cycle vrsp_vld=1, way=0, onehot=01.
//  2. Access set1 maps 01,10,04,40 (one per cycle), then vreq set1 valid=FF -> way=1. A vreq on set0 -> way=0 (set isolation).
//  3. Reset state, vreq valid=F7 -> way=3. Valid=FF, lock=0F -> way=4. Lock=FF -> all_locked=1, way=0, onehot=00.
//  4. Hold vrsp_rdy=0 with a response pending for 3 cycles -> vreq_rdy=0 and vrsp_* stable. Then rdy=1 with vreq valid -> back-to-back responses.
//  5. Same cycle: access set0 map=01 and vreq set0 valid=FF -> way=0 (pre-update state). A following vreq -> way=4.
//  6. UPDATE_ON_VICT=1: two vreqs on set3, valid=FF -> ways 0 then 4. Then flush_i -> next vreq -> way 0. Asserting rstn_i low mid-hold -> vrsp_vld=0.

Source files
------------

// File: rtl/plru_tree_set_ctrl.sv
// Multi-set tree pseudo-LRU controller: one (WAYS-1)-bit tree per set, updated from access maps,
// with a registered victim response (invalid-way priority, lock-aware tree walk).
`timescale 1ns/1ps
module plru_tree_set_ctrl #(
    parameter int WAYS           = 8,
    parameter int SETS           = 64,
    parameter int UPDATE_ON_VICT = 0,
    localparam int SET_W         = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int WAY_W         = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             access_vld_i,
    input  logic [SET_W-1:0] access_set_i,
    input  logic [WAYS-1:0]  access_map_i,
    input  logic             vreq_vld_i,
    output logic             vreq_rdy_o,
    input  logic [SET_W-1:0] vreq_set_i,
    input  logic [WAYS-1:0]  vreq_valid_map_i,
    input  logic [WAYS-1:0]  vreq_lock_map_i,
    output logic             vrsp_vld_o,
    input  logic             vrsp_rdy_i,
    output logic [WAY_W-1:0] vrsp_way_o,
    output logic [WAYS-1:0]  vrsp_onehot_o,
    output logic             vrsp_all_locked_o
);

    localparam int NODES = WAYS - 1;
    localparam logic [SET_W:0] SETS_L = (SET_W + 1)'(SETS);

    // Ways covered by the low (hi=0) or high (hi=1) child of a heap-ordered node.
    function automatic logic [WAYS-1:0] node_mask(input int node, input logic hi);
        int depth;
        int span;
        int base;
        depth = 0;
        for (int l = 0; l < WAY_W; l++)
            if (node >= (1 << l) - 1) depth = l;
        span = WAYS >> depth;
        base = (node - ((1 << depth) - 1)) * span + (hi ? span / 2 : 0);
        node_mask = '0;
        for (int w = 0; w < WAYS; w++)
            if (w >= base && w < base + span / 2) node_mask[w] = 1'b1;
    endfunction

    logic [NODES-1:0] tree_q [SETS];
    logic [NODES-1:0] tree_d [SETS];

    logic             vrsp_vld_q, vrsp_vld_d;
    logic [WAY_W-1:0] vrsp_way_q, vrsp_way_d;
    logic [WAYS-1:0]  vrsp_onehot_q, vrsp_onehot_d;
    logic             vrsp_all_locked_q, vrsp_all_locked_d;

    logic             vreq_acc;
    logic             vict_upd;
    logic             same_set;
    logic             all_locked;
    logic [WAYS-1:0]  free_map;
    logic [WAYS-1:0]  vict_oh;
    logic [WAYS-1:0]  acc_map;
    logic [WAY_W-1:0] vict_way;
    logic [WAY_W:0]   walk_node;
    logic             walk_dir;
    logic [NODES-1:0] acc_cur, vic_cur;
    logic [NODES-1:0] acc_flip, vic_flip;
    logic [NODES-1:0] lo_lk, hi_lk;

    assign vreq_rdy_o = ~flush_i & (~vrsp_vld_q | vrsp_rdy_i);
    assign vreq_acc   = vreq_vld_i & vreq_rdy_o;
    assign acc_cur    = tree_q[access_set_i];
    assign vic_cur    = tree_q[vreq_set_i];
    assign same_set   = access_vld_i & (access_set_i == vreq_set_i);
    assign free_map   = ~vreq_valid_map_i & ~vreq_lock_map_i;
    assign all_locked = &vreq_lock_map_i;
    assign vict_upd   = (UPDATE_ON_VICT != 0) & vreq_acc & ~all_locked;
    // A same-set victim update is folded into the access map so one update covers both.
    assign acc_map    = access_map_i | ((vict_upd & same_set) ? vict_oh : '0);

    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
        localparam logic [WAYS-1:0] LO_M = node_mask(gi, 1'b0);
        localparam logic [WAYS-1:0] HI_M = node_mask(gi, 1'b1);
        assign acc_flip[gi] = acc_cur[gi] ? |(acc_map & HI_M) : |(acc_map & LO_M);
        assign vic_flip[gi] = vic_cur[gi] ? |(vict_oh & HI_M) : |(vict_oh & LO_M);
        assign lo_lk[gi]    = &(vreq_lock_map_i | ~LO_M);
        assign hi_lk[gi]    = &(vreq_lock_map_i | ~HI_M);
    end

    always_comb begin
        vict_way  = '0;
        walk_node = '0;
        walk_dir  = 1'b0;
        if (|free_map) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (free_map[w]) vict_way = WAY_W'(w);
        end else if (!all_locked) begin
            for (int d = 0; d < WAY_W; d++) begin
                walk_dir = vic_cur[walk_node[WAY_W-1:0]];
                if (walk_dir ? hi_lk[walk_node[WAY_W-1:0]] : lo_lk[walk_node[WAY_W-1:0]])
                    walk_dir = ~walk_dir;
                walk_node = {walk_node[WAY_W-1:0], 1'b0} + (WAY_W + 1)'(1) + (WAY_W + 1)'(walk_dir);
            end
            vict_way = WAY_W'(walk_node - (WAY_W + 1)'(NODES));
        end
        vict_oh           = '0;
        vict_oh[vict_way] = ~all_locked;
    end

    always_comb begin
        tree_d = tree_q;
        if (flush_i) begin
            for (int s = 0; s < SETS; s++) tree_d[s] = '0;
        end else begin
            if (vict_upd && !same_set) tree_d[vreq_set_i] = vic_cur ^ vic_flip;
            if (access_vld_i) tree_d[access_set_i] = acc_cur ^ acc_flip;
        end
    end

    always_comb begin
        vrsp_vld_d        = vrsp_vld_q;
        vrsp_way_d        = vrsp_way_q;
        vrsp_onehot_d     = vrsp_onehot_q;
        vrsp_all_locked_d = vrsp_all_locked_q;
        if (vreq_acc) begin
            vrsp_vld_d        = 1'b1;
            vrsp_way_d        = vict_way;
            vrsp_onehot_d     = vict_oh;
            vrsp_all_locked_d = all_locked;
        end else if (vrsp_rdy_i) begin
            vrsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
            vrsp_vld_q        <= 1'b0;
            vrsp_way_q        <= '0;
            vrsp_onehot_q     <= '0;
            vrsp_all_locked_q <= 1'b0;
        end else begin
            tree_q            <= tree_d;
            vrsp_vld_q        <= vrsp_vld_d;
            vrsp_way_q        <= vrsp_way_d;
            vrsp_onehot_q     <= vrsp_onehot_d;
            vrsp_all_locked_q <= vrsp_all_locked_d;
        end
    end

    assign vrsp_vld_o        = vrsp_vld_q;
    assign vrsp_way_o        = vrsp_way_q;
    assign vrsp_onehot_o     = vrsp_onehot_q;
    assign vrsp_all_locked_o = vrsp_all_locked_q;

    a_access_set_range : assert property (@(posedge clk_i) disable iff (!rstn_i)
        access_vld_i |-> ({1'b0, access_set_i} < SETS_L));
    a_vreq_set_range : assert property (@(posedge clk_i) disable iff (!rstn_i)
        vreq_vld_i |-> ({1'b0, vreq_set_i} < SETS_L));

endmodule
